// File: rtl/counter_sequencer_pkg.sv
// counter_sequencer_pkg: state encoding and default width shared by counter_sequencer and counter_en
package counter_sequencer_pkg;

    localparam int N_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/counter_en.sv
// counter_en: N-bit up-counter with async reset, synchronous clear (dominant) and count enable
module counter_en
    import counter_sequencer_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] count
);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: FSM sequencing counter_en through start/pause/stop count runs with a one-cycle done pulse.
// Define COUNTER_SEQUENCER_AUTO_RELOAD_EN for periodic mode (DONE reloads into RUN instead of IDLE).
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic [N-1:0] limit,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state
);

    state_t       st, st_nx;
    logic [N-1:0] limit_q;
    logic         clr, en, load, term;

    counter_en #(.N(N)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (en),
        .count (count)
    );

    // Detect one step early so the final increment and the DONE transition share an edge
    assign term = (count == limit_q - 1'b1);

    always_comb begin
        st_nx = st;
        clr   = 1'b0;
        en    = 1'b0;
        load  = 1'b0;
        case (st)
            IDLE: begin
                clr = 1'b1;
                if (!stop && start) begin
                    load  = 1'b1;
                    st_nx = (limit == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    st_nx = IDLE;
                    clr   = 1'b1;
                end else if (pause) begin
                    st_nx = HOLD;
                end else begin
                    en    = 1'b1;
                    st_nx = term ? DONE : RUN;
                end
            end
            HOLD: begin
                if (stop) begin
                    st_nx = IDLE;
                    clr   = 1'b1;
                end else if (!pause) begin
                    st_nx = RUN;
                end
            end
            DONE: begin
                clr = 1'b1;
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
                // A zero limit means a period of one cycle, so DONE repeats every cycle
                st_nx = stop ? IDLE : ((limit_q == '0) ? DONE : RUN);
`else
                st_nx = IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st      <= IDLE;
            limit_q <= '0;
        end else begin
            st <= st_nx;
            if (load)
                limit_q <= limit;
        end

    assign state = st;
    assign done  = (st == DONE);
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
    assign busy  = (st != IDLE);
`else
    assign busy  = (st == RUN) || (st == HOLD);
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: scoreboard bench for counter_sequencer; covers periodic mode when
// COUNTER_SEQUENCER_AUTO_RELOAD_EN is defined.
module tb_counter_sequencer;
    import counter_sequencer_pkg::*;

    localparam int N = 5;
    localparam int W = N + 4;
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start, stop, pause;
    logic [N-1:0] limit, count;
    logic         busy, done;
    logic [1:0]   state;

    int checks = 0, errors = 0;
    int cyc, done_n, done_cyc;

    state_t       m_state;
    logic [N-1:0] m_count, m_limit;
    logic [W-1:0] exp_q[$], obs_q[$];

    counter_sequencer #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .pause (pause),
        .limit (limit),
        .count (count),
        .busy  (busy),
        .done  (done),
        .state (state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Behavioural reference: next state/count for one edge given the inputs
    task automatic model(input logic st, input logic sp, input logic pa, input logic [N-1:0] lim);
        case (m_state)
            IDLE: begin
                m_count = '0;
                if (!sp && st) begin
                    m_limit = lim;
                    m_state = (lim == 0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (sp) begin
                    m_state = IDLE;
                    m_count = '0;
                end else if (pa) begin
                    m_state = HOLD;
                end else begin
                    m_count = m_count + 1'b1;
                    if (m_count == m_limit) m_state = DONE;
                end
            end
            HOLD: begin
                if (sp) begin
                    m_state = IDLE;
                    m_count = '0;
                end else if (!pa) begin
                    m_state = RUN;
                end
            end
            DONE: begin
                m_count = '0;
                if (AUTO && !sp) m_state = (m_limit == 0) ? DONE : RUN;
                else m_state = IDLE;
            end
        endcase
    endtask

    function automatic logic [W-1:0] pack_exp();
        logic b, d;
        b = (m_state == RUN) || (m_state == HOLD) || (AUTO && m_state == DONE);
        d = (m_state == DONE);
        return {m_state, m_count, b, d};
    endfunction

    task automatic step(input logic st, input logic sp, input logic pa, input logic [N-1:0] lim);
        start = st;
        stop  = sp;
        pause = pa;
        limit = lim;
        model(st, sp, pa, lim);
        exp_q.push_back(pack_exp());
        @(posedge clk);
        #1;
        cyc++;
        obs_q.push_back({state, count, busy, done});
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
    endtask

    task automatic reset_dut();
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        limit = '0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_state  = IDLE;
        m_count  = '0;
        m_limit  = '0;
        cyc      = 0;
        done_n   = 0;
        done_cyc = -1;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        logic [W-1:0] o;
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; limit = '0;
        #1 rst = 1'b1;
        #1;
        o = {state, count, busy, done};
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset_async: state/count/busy/done got %h exp %h", o, {W{1'b0}});
        end
        reset_dut();
        o = {state, count, busy, done};
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset_release: state/count/busy/done got %h exp %h", o, {W{1'b0}});
        end
    endtask

    task automatic test_one_shot();
        logic [W-1:0] e, o;
        reset_dut();
        step(1, 0, 0, 5);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL one_shot_seq: got %h exp %h", o, e);
            end
        end
        checks++;
        if (done_n !== 1 || done_cyc !== 6) begin
            errors++;
            $display("FAIL one_shot_latency: pulses %0d at cyc %0d, exp 1 at cyc 6", done_n, done_cyc);
        end
    endtask

    task automatic test_pause();
        logic [W-1:0] e, o;
        reset_dut();
        step(1, 0, 0, 6);
        for (int i = 0; i < 10; i++) step(0, 0, (i == 2 || i == 3), 6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pause_seq: got %h exp %h", o, e);
            end
        end
        checks++;
        if (done_n !== 1 || done_cyc !== 10) begin
            errors++;
            $display("FAIL pause_latency: pulses %0d at cyc %0d, exp 1 at cyc 10", done_n, done_cyc);
        end
    endtask

    task automatic test_stop();
        logic [W-1:0] e, o;
        reset_dut();
        step(1, 0, 0, 10);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 10);
        step(1, 1, 1, 10);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stop_seq: got %h exp %h", o, e);
            end
        end
        checks++;
        if (done_n !== 0) begin
            errors++;
            $display("FAIL stop_no_done: pulses %0d exp 0", done_n);
        end
    endtask

    task automatic test_zero_limit();
        logic [W-1:0] e, o;
        reset_dut();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL zero_limit_seq: got %h exp %h", o, e);
            end
        end
        checks++;
        if (done_cyc < 1 || done_n < 1) begin
            errors++;
            $display("FAIL zero_limit_done: first pulse count %0d last cyc %0d, exp pulse at cyc 1", done_n, done_cyc);
        end
    endtask

    task automatic test_max_limit();
        logic [W-1:0] e, o;
        reset_dut();
        step(1, 0, 0, 31);
        for (int i = 0; i < 32; i++) step(0, 0, 0, 31);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL max_limit_seq: got %h exp %h", o, e);
            end
        end
        checks++;
        if (done_n < 1 || done_cyc < 32) begin
            errors++;
            $display("FAIL max_limit_done: pulses %0d last cyc %0d, exp first pulse at cyc 32", done_n, done_cyc);
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] e, o;
        reset_dut();
        step(1, 0, 0, 10);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 10);
        #2 rst = 1'b1;
        #1;
        o = {state, count, busy, done};
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL async_reset_mid_run: got %h exp %h", o, {W{1'b0}});
        end
        start = 1'b1;
        limit = 5'd4;
        @(posedge clk);
        #1;
        checks++;
        if (state !== 2'b00 || count !== '0) begin
            errors++;
            $display("FAIL async_reset_start_ignored: state %b count %0d exp 00/0", state, count);
        end
        rst     = 1'b0;
        m_state = IDLE;
        m_count = '0;
        m_limit = '0;
        step(1, 0, 0, 4);
        step(0, 0, 0, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL async_reset_seq: got %h exp %h", o, e);
            end
        end
    endtask

`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic [W-1:0] e, o;
        reset_dut();
        step(1, 0, 0, 3);
        for (int i = 0; i < 11; i++) step(0, 0, 0, (i < 5) ? 5'd3 : 5'd7);
        checks++;
        if (done_n !== 3 || done_cyc !== 12) begin
            errors++;
            $display("FAIL auto_reload_period: pulses %0d last cyc %0d, exp 3 last cyc 12", done_n, done_cyc);
        end
        step(0, 1, 0, 7);
        step(1, 0, 0, 7);
        step(0, 0, 0, 7);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL auto_reload_seq: got %h exp %h", o, e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_one_shot();
        test_pause();
        test_stop();
        test_zero_limit();
        test_max_limit();
        test_async_reset();
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
